// File: rtl/btn_debounce_pulse_pkg.sv
// Shared types and constants for the push-button debouncer.
// The default debounce length is exported here so that board-level wrappers can use it.
package btn_debounce_pulse_pkg;

  localparam int STATE_W              = 2;
  localparam int DEBOUNCE_CYC_DEFAULT = 50000;

  typedef enum logic [STATE_W-1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } btn_state_t;

endpackage

// File: rtl/btn_debounce_pulse_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Reset forces both stages to 0, so a released reset never produces a spurious edge.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Button conditioner: synchronise the raw pin, require DEBOUNCE_CYC stable cycles,
// then report a clean level plus one-cycle press and release strobes.
module btn_debounce_pulse
  import btn_debounce_pulse_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  // Terminal count; DEBOUNCE_CYC may equal 2^CNT_W, so DEBOUNCE_CYC-1 still fits.
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DEBOUNCE_CYC - 1);

  logic             btn_sync;
  btn_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             rel_reg, rel_next;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (btn_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_LOW;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      rel_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      press_reg <= press_next;
      rel_reg   <= rel_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    press_next = 1'b0;
    rel_next   = 1'b0;
    case (state_reg)
      S_LOW: begin
        if (btn_sync) begin
          state_next = S_RISE;
          cnt_next   = '0;
        end
      end
      S_RISE: begin
        // Any reversal while counting is treated as bounce and restarts from scratch.
        if (!btn_sync) begin
          state_next = S_LOW;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_END) begin
          state_next = S_HIGH;
          cnt_next   = '0;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!btn_sync) begin
          state_next = S_FALL;
          cnt_next   = '0;
        end
      end
      S_FALL: begin
        if (btn_sync) begin
          state_next = S_HIGH;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_END) begin
          state_next = S_LOW;
          cnt_next   = '0;
          level_next = 1'b0;
          rel_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = S_LOW;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
  end

  assign btn_level   = level_reg;
  assign btn_press   = press_reg;
  assign btn_release = rel_reg;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: three parameterisations share one button input and are
// compared every cycle against a run-length reference model, plus directed latency checks.
module tb_btn_debounce_pulse;

  localparam int NI = 3;
  localparam int DCYC [NI] = '{4, 1, 8};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn = 1'b0;
  logic [NI-1:0] lvl, prs, rel;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: input delay line plus per-instance run length of disagreeing samples
  bit hist [$];
  int run_m [NI];
  bit lvl_m [NI];
  bit prs_m [NI];
  bit rel_m [NI];

  // Event bookkeeping relative to a marked edge
  int edge_no;
  int first_press [NI];
  int first_rel   [NI];
  int press_cnt   [NI];
  int rel_cnt     [NI];

  always #5 clk = ~clk;

  btn_debounce_pulse #(.CNT_W(16), .DEBOUNCE_CYC(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn),
    .btn_level(lvl[0]), .btn_press(prs[0]), .btn_release(rel[0]));

  btn_debounce_pulse #(.CNT_W(16), .DEBOUNCE_CYC(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn),
    .btn_level(lvl[1]), .btn_press(prs[1]), .btn_release(rel[1]));

  btn_debounce_pulse #(.CNT_W(3), .DEBOUNCE_CYC(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn),
    .btn_level(lvl[2]), .btn_press(prs[2]), .btn_release(rel[2]));

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = '{1'b0, 1'b0};
    for (int i = 0; i < NI; i++) begin
      run_m[i] = 0; lvl_m[i] = 0; prs_m[i] = 0; rel_m[i] = 0;
    end
  endtask

  // A change is accepted once DEBOUNCE_CYC+1 consecutive synchronised samples disagree
  // with the current level (the first one starts the count, DEBOUNCE_CYC more complete it).
  task automatic model_step(input bit din);
    bit seen;
    seen = hist.pop_front();
    hist.push_back(din);
    for (int i = 0; i < NI; i++) begin
      prs_m[i] = 0;
      rel_m[i] = 0;
      if (seen != lvl_m[i]) begin
        run_m[i]++;
        if (run_m[i] == DCYC[i] + 1) begin
          lvl_m[i] = seen;
          prs_m[i] = seen;
          rel_m[i] = !seen;
          run_m[i] = 0;
        end
      end else begin
        run_m[i] = 0;
      end
    end
  endtask

  task automatic mark();
    edge_no = 0;
    for (int i = 0; i < NI; i++) begin
      first_press[i] = 0; first_rel[i] = 0; press_cnt[i] = 0; rel_cnt[i] = 0;
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step(btn);
    edge_no++;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("level[%0d] edge %0d", i, edge_no), lvl[i], lvl_m[i]);
      check($sformatf("press[%0d] edge %0d", i, edge_no), prs[i], prs_m[i]);
      check($sformatf("release[%0d] edge %0d", i, edge_no), rel[i], rel_m[i]);
      if (prs[i]) begin
        press_cnt[i]++;
        if (first_press[i] == 0) first_press[i] = edge_no;
      end
      if (rel[i]) begin
        rel_cnt[i]++;
        if (first_rel[i] == 0) first_rel[i] = edge_no;
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step_cycle();
  endtask

  initial begin
    model_reset();
    mark();
    #23;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset level[%0d]", i), lvl[i], 0);
      check($sformatf("reset press[%0d]", i), prs[i], 0);
      check($sformatf("reset release[%0d]", i), rel[i], 0);
    end
    @(negedge clk) rst_n = 1'b1;
    run(10);

    // Clean press, then hold long: one strobe on edge DEBOUNCE_CYC+3, no repeats
    btn = 1'b1; mark(); run(130);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("press latency[%0d]", i), first_press[i], DCYC[i] + 3);
      check($sformatf("press count[%0d]", i), press_cnt[i], 1);
      check($sformatf("release during press[%0d]", i), rel_cnt[i], 0);
    end

    // Clean release
    btn = 1'b0; mark(); run(30);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("release latency[%0d]", i), first_rel[i], DCYC[i] + 3);
      check($sformatf("release count[%0d]", i), rel_cnt[i], 1);
      check($sformatf("press during release[%0d]", i), press_cnt[i], 0);
    end

    // Bounce: high 3, low 1, then high held; D=4 presses 7 edges after the final rise
    btn = 1'b1; run(3);
    btn = 1'b0; run(1);
    btn = 1'b1; mark(); run(30);
    check("bounce press latency[0]", first_press[0], 7);
    check("bounce press count[0]", press_cnt[0], 1);
    btn = 1'b0; run(30);

    // Short glitch of 2 cycles must be invisible to the D=4 and D=8 instances
    mark();
    btn = 1'b1; run(2);
    btn = 1'b0; run(30);
    check("glitch press[0]", press_cnt[0], 0);
    check("glitch press[2]", press_cnt[2], 0);
    check("glitch level[0]", lvl[0], 0);

    // Reset mid-debounce (D=1 instance has already reached level 1 by then)
    btn = 1'b1; run(4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("async reset level[%0d]", i), lvl[i], 0);
      check($sformatf("async reset press[%0d]", i), prs[i], 0);
    end
    @(negedge clk) rst_n = 1'b1;
    mark(); run(30);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("post-reset latency[%0d]", i), first_press[i], DCYC[i] + 3);
      check($sformatf("post-reset count[%0d]", i), press_cnt[i], 1);
    end

    // Randomised bouncy holds; most short, some long enough to be accepted
    for (int seg = 0; seg < 300; seg++) begin
      btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) run($urandom_range(10, 25));
      else run($urandom_range(1, 9));
    end
    btn = 1'b0; run(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
